// File: rtl/image_stream_out_if.sv
// BRAM read port plus downstream FIFO write port for image_stream_out.
// master = streamer side, slave = BRAM/FIFO side.
interface image_stream_out_if #(
    parameter int unsigned PIXEL_BITS = 24,
    parameter int unsigned ADDR_BITS  = 20
);
    logic                  bram_rd_en;
    logic [ADDR_BITS-1:0]  bram_rd_addr;
    logic [PIXEL_BITS-1:0] bram_rd_data;
    logic                  out_full;
    logic                  out_wr_en;
    logic [PIXEL_BITS-1:0] out_din;

    modport master (
        output bram_rd_en, bram_rd_addr, out_wr_en, out_din,
        input  bram_rd_data, out_full
    );

    modport slave (
        input  bram_rd_en, bram_rd_addr, out_wr_en, out_din,
        output bram_rd_data, out_full
    );
endinterface

// File: rtl/image_stream_out.sv
// Streams a finished frame from image BRAM into a downstream FIFO via a 2-entry skid buffer.
// Define IMAGE_STREAM_ROW_FLIP_EN to emit rows bottom-up (BMP order).
module image_stream_out #(
    parameter int unsigned WIDTH      = 1280,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned IMAGE_SIZE = WIDTH * HEIGHT,
    parameter int unsigned PIXEL_BITS = 24,
    parameter int unsigned ADDR_BITS  = $clog2(IMAGE_SIZE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    image_stream_out_if.master  bus,
    output logic                busy,
    output logic                done
);

    localparam int unsigned COL_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ADDR_BITS:0]   LastIssue = (ADDR_BITS + 1)'(IMAGE_SIZE - 1);
    localparam logic [COL_BITS-1:0]  LastCol   = COL_BITS'(WIDTH - 1);
    localparam logic [ADDR_BITS-1:0] RowStep   = ADDR_BITS'(WIDTH);
`ifdef IMAGE_STREAM_ROW_FLIP_EN
    localparam logic [ADDR_BITS-1:0] RowBaseInit = ADDR_BITS'((HEIGHT - 1) * WIDTH);
`else
    localparam logic [ADDR_BITS-1:0] RowBaseInit = '0;
`endif

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS:0]    issued_q, issued_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [ADDR_BITS-1:0]  row_base_q, row_base_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  in_flight_q;
    logic [PIXEL_BITS-1:0] buf_q [2];
    logic [PIXEL_BITS-1:0] buf_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  pop;
    logic                  rd_en;
    logic [ADDR_BITS-1:0]  cur_addr;

    // Issue only while buffered + in-flight after this cycle's pop leaves room.
    always_comb begin
        pop      = (cnt_q != 2'd0) && !bus.out_full;
        cnt_d    = cnt_q + {1'b0, in_flight_q} - {1'b0, pop};
        rd_en    = (state_q == StRead) && (issued_q <= LastIssue) && (cnt_d < 2'd2);
        cur_addr = row_base_q + ADDR_BITS'(col_q);
    end

    always_comb begin
        issued_d   = issued_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        rd_addr_d  = rd_addr_q;
        if (state_q == StIdle && start) begin
            issued_d   = '0;
            col_d      = '0;
            row_base_d = RowBaseInit;
        end else if (rd_en) begin
            issued_d  = issued_q + 1'b1;
            rd_addr_d = cur_addr;
            if (col_q == LastCol) begin
                col_d = '0;
`ifdef IMAGE_STREAM_ROW_FLIP_EN
                row_base_d = row_base_q - RowStep;
`else
                row_base_d = row_base_q + RowStep;
`endif
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // BRAM data lands one cycle after the read, straight into the skid buffer.
    always_comb begin
        buf_d = buf_q;
        if (in_flight_q) buf_d[wr_ptr_q] = bus.bram_rd_data;
        wr_ptr_d = wr_ptr_q ^ in_flight_q;
        rd_ptr_d = rd_ptr_q ^ pop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_q    <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            rd_addr_q   <= '0;
            in_flight_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            issued_q    <= issued_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
            rd_addr_q   <= rd_addr_d;
            in_flight_q <= rd_en;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  if (rd_en && issued_q == LastIssue) state_d = StDrain;
            // Look at the post-pop occupancy so done lands right after the last write.
            StDrain: if (!in_flight_q && cnt_d == 2'd0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.bram_rd_en   = rd_en;
        bus.bram_rd_addr = rd_en ? cur_addr : rd_addr_q;
        bus.out_wr_en    = pop;
        bus.out_din      = buf_q[rd_ptr_q];
        busy             = (state_q == StRead) || (state_q == StDrain);
        done             = (state_q == StDone);
    end

    buf_bound_a: assert property (@(posedge clock) disable iff (reset) cnt_q <= 2'd2);

endmodule

// File: tb/tb_image_stream_out.sv
// Scoreboard bench for image_stream_out at WIDTH=4, HEIGHT=3 with a data=address BRAM model.
module tb_image_stream_out;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int PB = 24;
    localparam int AB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    image_stream_out_if #(.PIXEL_BITS(PB), .ADDR_BITS(AB)) bus ();

    image_stream_out #(
        .WIDTH(W), .HEIGHT(H), .PIXEL_BITS(PB), .ADDR_BITS(AB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frame_wr = 0;
    int done_cnt = 0;
    int first_rd = -1;
    int first_wr = -1;
    int last_wr  = -1;
    int start_cyc = 0;
    int full_mode = 0;
    int frame_t0  = 0;
    bit prev_done = 1'b0;
    int exp_q[$];

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial bus.bram_rd_data = '0;
    initial forever begin
        @(posedge clock);
        if (bus.bram_rd_en) bus.bram_rd_data <= PB'(bus.bram_rd_addr);
    end

    initial begin
        bus.out_full = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (full_mode == 0) bus.out_full = 1'b0;
            else if ((cyc - frame_t0) >= 8 && (cyc - frame_t0) < 15) bus.out_full = 1'b1;
            else bus.out_full = cyc[0];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pix(input int k);
`ifdef IMAGE_STREAM_ROW_FLIP_EN
        return (H - 1 - k / W) * W + k % W;
`else
        return k;
`endif
    endfunction

    // Monitor: pops the scoreboard on every write and checks done framing.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (bus.bram_rd_en && first_rd < 0) first_rd = cyc;
            if (bus.out_wr_en) begin
                int e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("pixel", bus.out_din, e);
                check("no_write_while_full", bus.out_full, 0);
                check("busy_during_write", busy, 1);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                frame_wr++;
            end
            if (done) begin
                check("done_after_last_write", cyc - last_wr, 1);
                check("queue_empty_at_done", exp_q.size(), 0);
                check("busy_low_with_done", busy, 0);
                check("single_done_pulse", prev_done, 0);
                done_cnt++;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic pulse_start(input bit expect_frame);
        @(posedge clock);
        #1;
        start = 1'b1;
        if (expect_frame) begin
            for (int k = 0; k < N; k++) exp_q.push_back(exp_pix(k));
            frame_wr  = 0;
            first_rd  = -1;
            first_wr  = -1;
            start_cyc = cyc;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < 400) begin
            @(posedge clock);
            t++;
        end
        check({name, "_done_seen"}, done_cnt - d0, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (frame_wr < n && t < 200) begin
            @(negedge clock);
            #1;
            t++;
        end
        check("writes_reached", frame_wr >= n, 1);
    endtask

    initial begin
        int w0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rd_en", bus.bram_rd_en, 0);
        check("rst_rd_addr", bus.bram_rd_addr, 0);
        check("rst_wr_en", bus.out_wr_en, 0);
        check("rst_din", bus.out_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Free-running frame
        pulse_start(1'b1);
        wait_done("plain");
        check("first_rd_latency", first_rd - start_cyc, 1);
        check("first_wr_latency", first_wr - first_rd, 2);
        check("writes_back_to_back", last_wr - first_wr, N - 1);
        check("plain_write_count", frame_wr, N);
        check("plain_busy_after", busy, 0);

        // Toggling full plus a 7-cycle hold
        full_mode = 1;
        frame_t0  = cyc;
        pulse_start(1'b1);
        wait_done("backpressure");
        check("bp_write_count", frame_wr, N);
        full_mode = 0;

        // start while busy is ignored; a later start replays
        pulse_start(1'b1);
        wait_writes(5);
        pulse_start(1'b0);
        wait_done("restart_ignored");
        check("ignored_start_count", frame_wr, N);
        pulse_start(1'b1);
        wait_done("replay");
        check("replay_count", frame_wr, N);

        // Reset mid-frame
        pulse_start(1'b1);
        wait_writes(5);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_rd_en", bus.bram_rd_en, 0);
        check("mid_rst_rd_addr", bus.bram_rd_addr, 0);
        check("mid_rst_wr_en", bus.out_wr_en, 0);
        check("mid_rst_din", bus.out_din, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        w0 = frame_wr;
        repeat (20) @(posedge clock);
        #1;
        check("no_writes_after_reset", frame_wr - w0, 0);
        check("idle_after_reset", busy, 0);
        pulse_start(1'b1);
        wait_done("post_reset");
        check("post_reset_count", frame_wr, N);

        check("total_done_pulses", done_cnt, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/image_stream_out.md
# image_stream_out

Streams the finished frame out of the image BRAM after line drawing completes. On `start` it scans every pixel address once, absorbs the BRAM's 1-cycle read latency, and pushes 24-bit pixels into a downstream FIFO through a write-enable/full handshake. It is the output-side counterpart of the pixel-input FIFOs and feeds the BMP writer or host DMA path.

## Interface
- `WIDTH`, default 1280: pixels per row.
- `HEIGHT`, default 720: rows per frame.
- `IMAGE_SIZE`, default `WIDTH*HEIGHT`: total pixels.
- `PIXEL_BITS`, default 24: pixel width, {B,G,R} as stored.
- `ADDR_BITS`, default `$clog2(IMAGE_SIZE)`: BRAM address width.
- One clock; reset is asynchronous and active-high.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse, typically `finish_draw_a_line`; ignored while `busy`.
- `bram_rd_en` out 1: a read is issued this cycle.
- `bram_rd_addr` out ADDR_BITS: read address.
- `bram_rd_data` in PIXEL_BITS: read data, valid the cycle after the address was issued.
- `out_full` in 1: downstream FIFO full.
- `out_wr_en` out 1: write `out_din` this cycle.
- `out_din` out PIXEL_BITS: pixel to the FIFO.
- `busy` out 1: frame transfer in progress.
- `done` out 1: one-cycle pulse after the last pixel is written.

## Operation
- States:
  - IDLE: `start` moves to READ; all counters are cleared.
  - READ: issues addresses until all IMAGE_SIZE reads are issued, then goes to DRAIN.
  - DRAIN: waits until nothing is in flight and the buffer is empty, then goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Output buffer: 2-entry FIFO (skid) capturing `bram_rd_data` the cycle after every issued read.
- Read issue rule: `bram_rd_en` = (state==READ) & (issued < IMAGE_SIZE) & (buffered + in_flight − pop < 2), where pop = `out_wr_en`. This sustains one pixel per cycle with `out_full` low and never overflows the buffer.
- Write rule: `out_wr_en` = buffer non-empty & !`out_full`, combinational on `out_full`. `out_din` = buffer head; pop on `out_wr_en`.
- Address generation uses a row base register plus a column counter; no multiplier.
  - Column wraps at WIDTH−1 to 0 and advances the row base by WIDTH.
  - Default order is row 0 to HEIGHT−1: address sequence 0,1,…,IMAGE_SIZE−1.
- Pixel data passes through unmodified.
- Exactly IMAGE_SIZE writes per `start`. No drops, duplicates or reordering under any `out_full` pattern.
- `start` while `busy` is ignored. `start` on the DONE cycle is ignored.
- `bram_rd_addr` holds its last value when no read is issued.

## Timing
- Reset values: `bram_rd_en`=0, `bram_rd_addr`=0, `out_wr_en`=0, `out_din`=0, `busy`=0, `done`=0; state IDLE; buffer empty; in_flight=0.
- `start` is sampled at edge E0.
  - `busy` is high from the cycle after E0 until the DONE cycle (exclusive).
  - The first `bram_rd_en` is in the cycle after E0.
- Latency: first `out_wr_en` comes 2 cycles after the first `bram_rd_en` (1 cycle BRAM, 1 cycle buffer register).
- No backpressure: IMAGE_SIZE consecutive `out_wr_en` cycles. `done` is 1 cycle after the last write; `busy` falls with `done`.
- `out_full` rising stops writes in the same cycle. Reads stop once the buffer plus in-flight count reaches 2.
- `out_full` falling resumes writes in the same cycle.
- Reset mid-operation: every output goes to its reset value immediately (asynchronous). In-flight data is discarded; the BRAM return on the following cycle is ignored. The block stays idle until a new `start`.
- Counter widths: issued/written counters are ADDR_BITS+1 to avoid wrap at IMAGE_SIZE.

## Configuration
- `IMAGE_STREAM_ROW_FLIP_EN` defined: rows are emitted HEIGHT−1 down to 0, columns ascending. The row base starts at (HEIGHT−1)·WIDTH and decrements by WIDTH at each column wrap. This matches BMP bottom-up storage.
- Undefined: row base starts at 0 and increments by WIDTH (linear order).

## Test plan
- WIDTH=4, HEIGHT=3, BRAM model returns data = address, `out_full`=0:
  - `out_din` is 0..11 on 12 consecutive `out_wr_en` cycles.
  - First write comes 2 cycles after the first `bram_rd_en`.
  - A single `done` pulse follows the last write.
- Same setup, `out_full` toggled every cycle and also held for 7 cycles mid-frame:
  - Sequence 0..11 is intact.
  - `out_wr_en` is never high while `out_full` is high.
  - The buffer never exceeds 2 entries (assertion).
- `start` pulsed again at write 5:
  - It is ignored; exactly 12 writes occur.
  - A `start` after `done` replays 0..11.
- `reset` asserted for 2 cycles after the 5th write:
  - Outputs go to 0 in the same cycle.
  - No writes occur after release until a new `start`, which gives 0..11.
- With `IMAGE_STREAM_ROW_FLIP_EN`, WIDTH=4, HEIGHT=3: `out_din` = 8,9,10,11,4,5,6,7,0,1,2,3.
- Default parameters with random 30% `out_full`: exactly 921600 writes in address order, then `done`; `busy` is low afterward.
